// File: rtl/regfile_2w4r.sv
// regfile_2w4r: dual-issue integer register file, REG_NUM x DATA_W.
// Two write ports (slot 1 and slot 2, post-arbitration) and four
// combinational read ports (rs1/rs2 for each issue slot) with write-first
// bypass, so a read sees the value that the next clock edge commits.
// Register 0 always reads 0.
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 asynchronous active-high reset
//   we1/waddr1/wdata1   write port, slot 1
//   we2/waddr2/wdata2   write port, slot 2 (wins on an address clash)
//   raddr1_a/raddr1_b   slot-1 rs1/rs2 read addresses
//   raddr2_a/raddr2_b   slot-2 rs1/rs2 read addresses
//   rdata1_a..rdata2_b  read data (combinational, zero while rst is held)
//   wr_cnt              wrapping count of committed register writes
module regfile_2w4r #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] waddr2,
  input  logic [DATA_W-1:0] wdata2,
  input  logic [ADDR_W-1:0] raddr1_a,
  input  logic [ADDR_W-1:0] raddr1_b,
  input  logic [ADDR_W-1:0] raddr2_a,
  input  logic [ADDR_W-1:0] raddr2_b,
  output logic [DATA_W-1:0] rdata1_a,
  output logic [DATA_W-1:0] rdata1_b,
  output logic [DATA_W-1:0] rdata2_a,
  output logic [DATA_W-1:0] rdata2_b,
  output logic [7:0]        wr_cnt
);

  logic [DATA_W-1:0] r_regs [REG_NUM];
  logic [7:0]        r_wr_cnt;

  logic              w_wr1_vld;
  logic              w_wr2_vld;
  logic              w_wr1_eff;
  logic [ADDR_W-1:0] w_raddr [4];
  logic [DATA_W-1:0] w_rdata [4];

  assign w_wr1_vld = we1 && (waddr1 != '0);
  assign w_wr2_vld = we2 && (waddr2 != '0);
  // Slot 2 is the younger instruction: on a clash slot 1 neither writes
  // nor counts, so the counter moves by the number of distinct addresses.
  assign w_wr1_eff = w_wr1_vld && !(w_wr2_vld && (waddr1 == waddr2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_cnt <= '0;
    end else begin
      if (w_wr1_eff) begin
        r_regs[waddr1] <= wdata1;
      end
      if (w_wr2_vld) begin
        r_regs[waddr2] <= wdata2;
      end
      r_wr_cnt <= r_wr_cnt + 8'(w_wr1_eff) + 8'(w_wr2_vld);
    end
  end

  assign w_raddr[0] = raddr1_a;
  assign w_raddr[1] = raddr1_b;
  assign w_raddr[2] = raddr2_a;
  assign w_raddr[3] = raddr2_b;

  // Write-first bypass. The rst gate keeps a pending write from showing
  // through while the array is held in reset.
  for (genvar p = 0; p < 4; p++) begin : g_rd
    always_comb begin
      w_rdata[p] = '0;
      if (!rst && (w_raddr[p] != '0)) begin
        if (w_wr2_vld && (waddr2 == w_raddr[p])) begin
          w_rdata[p] = wdata2;
        end else if (w_wr1_vld && (waddr1 == w_raddr[p])) begin
          w_rdata[p] = wdata1;
        end else begin
          w_rdata[p] = r_regs[w_raddr[p]];
        end
      end
    end
  end

  assign rdata1_a = w_rdata[0];
  assign rdata1_b = w_rdata[1];
  assign rdata2_a = w_rdata[2];
  assign rdata2_b = w_rdata[3];
  assign wr_cnt   = r_wr_cnt;

endmodule

// File: tb/tb_regfile_2w4r.sv
module tb_regfile_2w4r;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we1 = 1'b0, we2 = 1'b0;
  logic [4:0]  waddr1 = '0, waddr2 = '0;
  logic [31:0] wdata1 = '0, wdata2 = '0;
  logic [4:0]  raddr1_a = '0, raddr1_b = '0, raddr2_a = '0, raddr2_b = '0;
  logic [31:0] rdata1_a, rdata1_b, rdata2_a, rdata2_b;
  logic [7:0]  wr_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  // Behavioural model: architectural register contents and write count.
  logic [31:0] m_regs [32];
  int          m_cnt;

  regfile_2w4r dut (
    .clk(clk), .rst(rst),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .we2(we2), .waddr2(waddr2), .wdata2(wdata2),
    .raddr1_a(raddr1_a), .raddr1_b(raddr1_b),
    .raddr2_a(raddr2_a), .raddr2_b(raddr2_b),
    .rdata1_a(rdata1_a), .rdata1_b(rdata1_b),
    .rdata2_a(rdata2_a), .rdata2_b(rdata2_b),
    .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // What a read port must show given the pending writes and stored state.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (rst || a == 0) return 32'h0;
    if (we2 && waddr2 == a) return wdata2;
    if (we1 && waddr1 == a) return wdata1;
    return m_regs[a];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt = 0;
    end else begin
      int n;
      n = 0;
      if (we1 && waddr1 != 0) begin
        m_regs[waddr1] = wdata1;
        n++;
      end
      if (we2 && waddr2 != 0) begin
        m_regs[waddr2] = wdata2;  // applied second, so slot 2 wins
        if (!(we1 && waddr1 == waddr2)) n++;
      end
      m_cnt = (m_cnt + n) % 256;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("rd1a", rdata1_a, model_read(raddr1_a));
      check("rd1b", rdata1_b, model_read(raddr1_b));
      check("rd2a", rdata2_a, model_read(raddr2_a));
      check("rd2b", rdata2_b, model_read(raddr2_b));
      check("wr_cnt", {24'h0, wr_cnt}, 32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we1 = 0; we2 = 0; waddr1 = 0; waddr2 = 0; wdata1 = 0; wdata2 = 0;
  endtask

  task automatic set_rd(input logic [4:0] a);
    raddr1_a = a; raddr1_b = a; raddr2_a = a; raddr2_b = a;
  endtask

  task automatic check_all_ports(input string name, input logic [31:0] exp);
    check(name, rdata1_a, exp);
    check(name, rdata1_b, exp);
    check(name, rdata2_a, exp);
    check(name, rdata2_b, exp);
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    step();
    rst = 0;
    step();
  endtask

  initial begin
    chk_on = 1;
    step();
    step();
    rst = 0;
    step();
    check("post_reset_cnt", {24'h0, wr_cnt}, 32'h0);

    // Load reg5 then reset mid-run
    we1 = 1; waddr1 = 5; wdata1 = 32'h1234;
    step();
    idle();
    set_rd(5);
    #1;
    check_all_ports("reg5_loaded", 32'h1234);
    rst = 1;
    #1;
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a));
      #1;
      check_all_ports("reset_zero_held", 32'h0);
    end
    check("reset_cnt", {24'h0, wr_cnt}, 32'h0);
    step();
    rst = 0;
    step();
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a));
      #1;
      check_all_ports("reset_zero_after", 32'h0);
    end

    // Single write then read
    we1 = 1; waddr1 = 3; wdata1 = 32'hDEADBEEF;
    step();
    idle();
    raddr1_a = 3;
    #1;
    check("single_rd", rdata1_a, 32'hDEADBEEF);
    check("single_cnt", {24'h0, wr_cnt}, 32'd1);

    // Bypass
    we2 = 1; waddr2 = 7; wdata2 = 32'hA5A5A5A5; raddr2_b = 7;
    #1;
    check("bypass_same", rdata2_b, 32'hA5A5A5A5);
    step();
    idle();
    #1;
    check("bypass_after", rdata2_b, 32'hA5A5A5A5);
    check("bypass_cnt", {24'h0, wr_cnt}, 32'd2);

    // x0 protection
    we1 = 1; waddr1 = 0; wdata1 = 32'hFFFFFFFF;
    we2 = 1; waddr2 = 0; wdata2 = 32'hFFFFFFFF;
    set_rd(0);
    #1;
    check_all_ports("x0_same", 32'h0);
    step();
    idle();
    #1;
    check_all_ports("x0_after", 32'h0);
    check("x0_cnt", {24'h0, wr_cnt}, 32'd2);

    // Same-address conflict
    we1 = 1; waddr1 = 9; wdata1 = 32'h11;
    we2 = 1; waddr2 = 9; wdata2 = 32'h22;
    set_rd(9);
    #1;
    check_all_ports("conflict_same", 32'h22);
    step();
    idle();
    #1;
    check_all_ports("conflict_after", 32'h22);
    check("conflict_cnt", {24'h0, wr_cnt}, 32'd3);

    // Randomized traffic; small address pool forces clashes and bypass hits
    for (int c = 0; c < 3000; c++) begin
      we1 = 1'($urandom);
      we2 = 1'($urandom);
      waddr1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      waddr2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wdata1 = $urandom;
      wdata2 = $urandom;
      raddr1_a = ($urandom_range(0, 2) == 0) ? waddr1 : 5'($urandom);
      raddr1_b = ($urandom_range(0, 2) == 0) ? waddr2 : 5'($urandom);
      raddr2_a = 5'($urandom);
      raddr2_b = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      if ($urandom_range(0, 199) == 0) rst = 1;
      step();
      rst = 0;
    end
    idle();

    // Counter wrap: 254 + 2 -> 0
    do_reset();
    for (int i = 0; i < 254; i++) begin
      we1 = 1; waddr1 = 5'(1 + (i % 31)); wdata1 = 32'(i);
      step();
    end
    idle();
    #1;
    check("preload_254", {24'h0, wr_cnt}, 32'd254);
    we1 = 1; waddr1 = 4; wdata1 = 32'h44;
    we2 = 1; waddr2 = 5; wdata2 = 32'h55;
    step();
    idle();
    raddr1_a = 4; raddr2_a = 5;
    #1;
    check("wrap_reg4", rdata1_a, 32'h44);
    check("wrap_reg5", rdata2_a, 32'h55);
    check("wrap_cnt0", {24'h0, wr_cnt}, 32'd0);

    // 255 + 2 -> 1
    for (int i = 0; i < 255; i++) begin
      we2 = 1; waddr2 = 5'(1 + (i % 31)); wdata2 = 32'(i);
      step();
    end
    idle();
    #1;
    check("preload_255", {24'h0, wr_cnt}, 32'd255);
    we1 = 1; waddr1 = 10; wdata1 = 32'hA;
    we2 = 1; waddr2 = 11; wdata2 = 32'hB;
    step();
    idle();
    #1;
    check("wrap_cnt1", {24'h0, wr_cnt}, 32'd1);

    // 255 + 1 -> 0
    for (int i = 0; i < 254; i++) begin
      we1 = 1; waddr1 = 5'(1 + (i % 31)); wdata1 = 32'(i);
      step();
    end
    idle();
    #1;
    check("preload_255b", {24'h0, wr_cnt}, 32'd255);
    we1 = 1; waddr1 = 12; wdata1 = 32'hC;
    step();
    idle();
    #1;
    check("wrap_single", {24'h0, wr_cnt}, 32'd0);

    step();
    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
